// File: rtl/lu_serial_arbiter.sv
// rtl/lu_serial_arbiter.sv - two-requester round-robin arbiter feeding one shared bit-serial logic unit
module lu_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [1:0]       op_q;
  logic             id_q;
  logic [CW-1:0]    cnt;
  logic             prio;
  logic             grant0;
  logic             grant1;
  logic             a_bit;
  logic             b_bit;
  logic             lu_bit;

  // prio names the requester that wins a tie; it flips away from whoever was just granted
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !prio);
    grant1 = req1_valid && (!req0_valid || prio);
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign busy       = (state != IDLE);

  // The single shared 1-bit logic unit: op[1] picks OR/XOR, op[0] inverts
  assign a_bit  = a_q[cnt];
  assign b_bit  = b_q[cnt];
  assign lu_bit = (op_q[1] ? (a_bit ^ b_bit) : (a_bit | b_bit)) ^ op_q[0];

  always_comb begin
    acc_next      = acc;
    acc_next[cnt] = lu_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      cnt       <= '0;
      prio      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      id_q      <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q   <= grant1 ? req1_a : req0_a;
            b_q   <= grant1 ? req1_b : req0_b;
            op_q  <= grant1 ? req1_op : req0_op;
            id_q  <= grant1;
            prio  <= ~grant1;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          // Result is published only when complete so res_data holds steady outside DONE
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= acc_next;
            res_id    <= id_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
